// File: rtl/time_entry_buffer_if.sv
// Keypad entry bus: key strobe in, HH:MM digits plus load/busy/error status out.
interface time_entry_buffer_if;
   logic       key_valid;
   logic [3:0] key;
   logic [3:0] new_current_time_ms_hr;
   logic [3:0] new_current_time_ls_hr;
   logic [3:0] new_current_time_ms_min;
   logic [3:0] new_current_time_ls_min;
   logic       load_new_c;
   logic       load_new_a;
   logic       entry_busy;
   logic       entry_error;

   modport master (
      output key_valid, key,
      input  new_current_time_ms_hr, new_current_time_ls_hr,
             new_current_time_ms_min, new_current_time_ls_min,
             load_new_c, load_new_a, entry_busy, entry_error
   );

   modport slave (
      input  key_valid, key,
      output new_current_time_ms_hr, new_current_time_ls_hr,
             new_current_time_ms_min, new_current_time_ls_min,
             load_new_c, load_new_a, entry_busy, entry_error
   );
endinterface

// File: rtl/time_entry_buffer.sv
// Keypad HH:MM entry buffer with SET_TIME / SET_ALARM load strobes and idle timeout.
// Define ENTRY_RANGE_CHECK_EN to reject entries outside 00:00-23:59.
module time_entry_buffer #(
   parameter int TIMEOUT_CYCLES = 2560,
   parameter int TO_W           = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   time_entry_buffer_if.slave   bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      ENTRY = 1'b1
   } state_t;

   localparam logic [3:0]      KEY_SET_TIME  = 4'hA;
   localparam logic [3:0]      KEY_SET_ALARM = 4'hB;
   localparam logic [3:0]      KEY_CLEAR     = 4'hC;
   localparam logic [TO_W-1:0] TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q;
   logic [3:0]      ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   logic [2:0]      cnt_q;
   logic [TO_W-1:0] to_q;
   logic            load_c_q, load_a_q, err_q;

   logic key_digit, key_time, key_alarm, key_clear;
   logic range_ok, cmd_ok;

   assign key_digit = bus.key_valid && (bus.key <= 4'd9);
   assign key_time  = bus.key_valid && (bus.key == KEY_SET_TIME);
   assign key_alarm = bus.key_valid && (bus.key == KEY_SET_ALARM);
   assign key_clear = bus.key_valid && (bus.key == KEY_CLEAR);

`ifdef ENTRY_RANGE_CHECK_EN
   // 20-23 allowed, 24-29 not; minutes tens 0-5.
   assign range_ok = (ms_hr_q <= 4'd2) && (ms_min_q <= 4'd5) &&
                     !((ms_hr_q == 4'd2) && (ls_hr_q > 4'd3));
`else
   assign range_ok = 1'b1;
`endif

   assign cmd_ok = (cnt_q == 3'd4) && range_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ms_hr_q  <= 4'h0;
         ls_hr_q  <= 4'h0;
         ms_min_q <= 4'h0;
         ls_min_q <= 4'h0;
         cnt_q    <= 3'd0;
         to_q     <= '0;
         load_c_q <= 1'b0;
         load_a_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         load_c_q <= 1'b0;
         load_a_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_digit) begin
                  ms_hr_q  <= 4'h0;
                  ls_hr_q  <= 4'h0;
                  ms_min_q <= 4'h0;
                  ls_min_q <= bus.key;
                  cnt_q    <= 3'd1;
                  to_q     <= '0;
                  state_q  <= ENTRY;
               end
            end
            ENTRY: begin
               if (key_digit) begin
                  ms_hr_q  <= ls_hr_q;
                  ls_hr_q  <= ms_min_q;
                  ms_min_q <= ls_min_q;
                  ls_min_q <= bus.key;
                  if (cnt_q != 3'd4) cnt_q <= cnt_q + 3'd1;
                  to_q     <= '0;
               end else if (key_time || key_alarm) begin
                  if (cmd_ok) begin
                     load_c_q <= key_time;
                     load_a_q <= key_alarm;
                  end else begin
                     err_q    <= 1'b1;
                  end
                  cnt_q   <= 3'd0;
                  to_q    <= '0;
                  state_q <= IDLE;
               end else if (key_clear || (to_q == TO_LAST)) begin
                  // Abort keeps the digits on display; only the count is dropped.
                  cnt_q   <= 3'd0;
                  to_q    <= '0;
                  state_q <= IDLE;
               end else begin
                  to_q <= to_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.new_current_time_ms_hr  = ms_hr_q;
   assign bus.new_current_time_ls_hr  = ls_hr_q;
   assign bus.new_current_time_ms_min = ms_min_q;
   assign bus.new_current_time_ls_min = ls_min_q;
   assign bus.load_new_c              = load_c_q;
   assign bus.load_new_a              = load_a_q;
   assign bus.entry_busy              = (state_q == ENTRY);
   assign bus.entry_error             = err_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Bench for time_entry_buffer: directed scenarios plus randomized keys against a digit-queue model.
module tb_time_entry_buffer;

   localparam int TO   = 24;
   localparam int TO_W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   time_entry_buffer_if tif ();

   time_entry_buffer #(.TIMEOUT_CYCLES(TO), .TO_W(TO_W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (tif)
   );

   always #5 clk = ~clk;

   wire [15:0] dut_digits = {tif.new_current_time_ms_hr, tif.new_current_time_ls_hr,
                             tif.new_current_time_ms_min, tif.new_current_time_ls_min};
   wire [2:0]  dut_flags  = {tif.load_new_c, tif.load_new_a, tif.entry_error};

   // Reference model: the last entered digits as a 4-entry list, an entry flag,
   // the number of digits typed and the number of silent cycles since the last key.
   int m_buf[4];
   bit m_busy;
   int m_cnt;
   int m_idle;
   bit m_c, m_a, m_err;

   function automatic bit time_legal();
`ifdef ENTRY_RANGE_CHECK_EN
      return ((m_buf[0] * 10 + m_buf[1]) < 24) && ((m_buf[2] * 10 + m_buf[3]) < 60);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [15:0] model_digits();
      return {4'(m_buf[0]), 4'(m_buf[1]), 4'(m_buf[2]), 4'(m_buf[3])};
   endfunction

   function automatic logic [2:0] model_flags();
      return {m_c, m_a, m_err};
   endfunction

   task automatic model_reset();
      m_buf  = '{0, 0, 0, 0};
      m_busy = 0; m_cnt = 0; m_idle = 0;
      m_c = 0; m_a = 0; m_err = 0;
   endtask

   task automatic model_step(input bit v, input int k);
      m_c = 0; m_a = 0; m_err = 0;
      if (!m_busy) begin
         if (v && k <= 9) begin
            m_buf = '{0, 0, 0, k};
            m_cnt = 1; m_idle = 0; m_busy = 1;
         end
      end else if (v && k <= 9) begin
         m_buf = '{m_buf[1], m_buf[2], m_buf[3], k};
         m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
         m_idle = 0;
      end else if (v && (k == 10 || k == 11)) begin
         if (m_cnt == 4 && time_legal()) begin
            if (k == 10) m_c = 1; else m_a = 1;
         end else begin
            m_err = 1;
         end
         m_busy = 0; m_cnt = 0; m_idle = 0;
      end else if (v && k == 12) begin
         m_busy = 0; m_cnt = 0; m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            m_busy = 0; m_cnt = 0; m_idle = 0;
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge with the model updated.
   task automatic drive(input bit v, input logic [3:0] k);
      tif.key_valid = v;
      tif.key       = k;
      @(posedge clk);
      model_step(v, int'(k));
      @(negedge clk);
      tif.key_valid = 1'b0;
      tif.key       = 4'hF;
   endtask

   task automatic enter4(input logic [15:0] d);
      drive(1'b1, d[15:12]);
      drive(1'b1, d[11:8]);
      drive(1'b1, d[7:4]);
      drive(1'b1, d[3:0]);
   endtask

   task automatic test_reset();
      drive(1'b1, 4'd1);
      drive(1'b1, 4'd2);
      drive(1'b1, 4'd3);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_digits !== 16'h0000) begin
         n_fail++; $display("FAIL reset_digits got=%h exp=0000", dut_digits);
      end
      n_checks++;
      if ({tif.entry_busy, dut_flags} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_status got=%b exp=0000", {tif.entry_busy, dut_flags});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tif.entry_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release_busy got=%b exp=0", tif.entry_busy);
      end
   endtask

   task automatic test_load_time();
      enter4(16'h1234);
      n_checks++;
      if (tif.entry_busy !== 1'b1) begin
         n_fail++; $display("FAIL time_busy_during got=%b exp=1", tif.entry_busy);
      end
      drive(1'b1, 4'hA);
      n_checks++;
      if ({dut_flags, tif.entry_busy} !== 4'b1000) begin
         n_fail++; $display("FAIL time_strobe got=%b exp=1000", {dut_flags, tif.entry_busy});
      end
      n_checks++;
      if (dut_digits !== 16'h1234) begin
         n_fail++; $display("FAIL time_digits got=%h exp=1234", dut_digits);
      end
      drive(1'b0, 4'h0);
      n_checks++;
      if (dut_flags !== 3'b000 || dut_digits !== 16'h1234) begin
         n_fail++; $display("FAIL time_after got=%b/%h exp=000/1234", dut_flags, dut_digits);
      end
   endtask

   task automatic test_load_alarm();
      enter4(16'h0630);
      drive(1'b1, 4'hB);
      n_checks++;
      if (dut_flags !== 3'b010) begin
         n_fail++; $display("FAIL alarm_strobe got=%b exp=010", dut_flags);
      end
      n_checks++;
      if (dut_digits !== 16'h0630) begin
         n_fail++; $display("FAIL alarm_digits got=%h exp=0630", dut_digits);
      end
      drive(1'b0, 4'h0);
      n_checks++;
      if (dut_flags !== 3'b000) begin
         n_fail++; $display("FAIL alarm_one_cycle got=%b exp=000", dut_flags);
      end
   endtask

   task automatic test_range();
      logic [2:0] exp24;
      logic [2:0] exp1960;
`ifdef ENTRY_RANGE_CHECK_EN
      exp24 = 3'b001; exp1960 = 3'b001;
`else
      exp24 = 3'b100; exp1960 = 3'b100;
`endif
      enter4(16'h2400);
      drive(1'b1, 4'hA);
      n_checks++;
      if (dut_flags !== exp24 || dut_digits !== 16'h2400) begin
         n_fail++; $display("FAIL range_2400 got=%b/%h exp=%b/2400", dut_flags, dut_digits, exp24);
      end
      enter4(16'h2359);
      drive(1'b1, 4'hA);
      n_checks++;
      if (dut_flags !== 3'b100) begin
         n_fail++; $display("FAIL range_2359 got=%b exp=100", dut_flags);
      end
      enter4(16'h1960);
      drive(1'b1, 4'hB);
      n_checks++;
      if (dut_flags !== {exp1960[2] ? 3'b010 : exp1960}) begin
         n_fail++; $display("FAIL range_1960 got=%b", dut_flags);
      end
   endtask

   task automatic test_short_entry();
      drive(1'b1, 4'd1);
      drive(1'b1, 4'd2);
      drive(1'b1, 4'hA);
      n_checks++;
      if ({dut_flags, tif.entry_busy} !== 4'b0010) begin
         n_fail++; $display("FAIL short_error got=%b exp=0010", {dut_flags, tif.entry_busy});
      end
      drive(1'b1, 4'd9);
      enter4(16'h1234);
      drive(1'b1, 4'hA);
      n_checks++;
      if (dut_flags !== 3'b100 || dut_digits !== 16'h1234) begin
         n_fail++; $display("FAIL last_four got=%b/%h exp=100/1234", dut_flags, dut_digits);
      end
      drive(1'b1, 4'd1);
      drive(1'b1, 4'd2);
      drive(1'b1, 4'hC);
      drive(1'b1, 4'hA);
      n_checks++;
      if ({dut_flags, tif.entry_busy} !== 4'b0000 || dut_digits !== 16'h0012) begin
         n_fail++; $display("FAIL clear got=%b/%h exp=0000/0012", {dut_flags, tif.entry_busy}, dut_digits);
      end
   endtask

   task automatic test_timeout();
      int strobes;
      strobes = 0;
      drive(1'b1, 4'd5);
      for (int i = 0; i < TO - 1; i++) begin
         drive(1'b0, 4'h0);
         if (dut_flags != 3'b000) strobes++;
      end
      n_checks++;
      if (tif.entry_busy !== 1'b1) begin
         n_fail++; $display("FAIL timeout_early got=%b exp=1", tif.entry_busy);
      end
      drive(1'b0, 4'h0);
      n_checks++;
      if (tif.entry_busy !== 1'b0 || dut_flags !== 3'b000 || strobes != 0) begin
         n_fail++; $display("FAIL timeout_exit got=%b/%b strobes=%0d exp=0/000 0", tif.entry_busy, dut_flags, strobes);
      end
      drive(1'b1, 4'hA);
      n_checks++;
      if (dut_flags !== 3'b000 || dut_digits !== 16'h0005) begin
         n_fail++; $display("FAIL timeout_cmd_ignored got=%b/%h exp=000/0005", dut_flags, dut_digits);
      end
      // Digit landing on the timeout edge keeps the entry alive.
      drive(1'b1, 4'd5);
      for (int i = 0; i < TO - 1; i++) drive(1'b0, 4'h0);
      drive(1'b1, 4'd8);
      n_checks++;
      if (tif.entry_busy !== 1'b1 || dut_digits !== 16'h0058) begin
         n_fail++; $display("FAIL timeout_key_wins got=%b/%h exp=1/0058", tif.entry_busy, dut_digits);
      end
      drive(1'b1, 4'hC);
   endtask

   task automatic test_back_to_back();
      enter4(16'h1234);
      drive(1'b1, 4'hA);
      drive(1'b1, 4'd7);
      n_checks++;
      if ({dut_flags, tif.entry_busy} !== 4'b0001 || dut_digits !== 16'h0007) begin
         n_fail++; $display("FAIL b2b_key_in_strobe got=%b/%h exp=0001/0007", {dut_flags, tif.entry_busy}, dut_digits);
      end
      drive(1'b1, 4'hC);
   endtask

   task automatic test_random();
      int r;
      logic [3:0] k;
      bit v;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 60) == 0) begin
            for (int j = 0; j < TO; j++) begin
               drive(1'b0, 4'($urandom_range(0, 15)));
               n_checks++;
               if (tif.entry_busy !== m_busy || dut_flags !== model_flags()) begin
                  n_fail++; $display("FAIL rand_idle got=%b/%b exp=%b/%b", tif.entry_busy, dut_flags, m_busy, model_flags());
               end
            end
         end
         v = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         if (r < 10)       k = 4'(r);
         else if (r < 12)  k = 4'hA;
         else if (r < 14)  k = 4'hB;
         else if (r < 15)  k = 4'hC;
         else              k = 4'($urandom_range(13, 15));
         drive(v, k);
         n_checks++;
         if (dut_digits !== model_digits() || dut_flags !== model_flags() || tif.entry_busy !== m_busy) begin
            n_fail++;
            $display("FAIL rand_step%0d got=%h/%b/%b exp=%h/%b/%b", i, dut_digits, dut_flags,
                     tif.entry_busy, model_digits(), model_flags(), m_busy);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tif.key_valid = 1'b0;
      tif.key       = 4'hF;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_load_time();
      test_load_alarm();
      test_range();
      test_short_entry();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
